// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the core's data port.
// Word RAM with byte-lane writes and read-first synchronous read, plus a small
// MMIO block: 64-bit cycle counter with coherent high-word shadow and a sticky
// access-fault status/address pair.
module dmem_responder #(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     DEPTH_WORDS = 1024,
   parameter logic [XLEN-1:0] MMIO_BASE   = 32'hF000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] data_mem_addr,
   input  logic [XLEN-1:0] data_mem_wdata,
   input  logic [2:0]      data_mem_we,
   output logic [XLEN-1:0] data_mem_out,
   output logic            fault
);

   localparam int unsigned NB   = XLEN / 8;
   localparam int unsigned IDXW = $clog2(DEPTH_WORDS);
   localparam int unsigned CNTW = 64;
   localparam int unsigned FSW  = 3;

   localparam logic [2:0] WE_NONE = 3'b000;
   localparam logic [2:0] WE_BYTE = 3'b001;
   localparam logic [2:0] WE_HALF = 3'b010;
   localparam logic [2:0] WE_WORD = 3'b100;

   localparam logic [1:0] REG_CYCLE_LO = 2'd0;
   localparam logic [1:0] REG_CYCLE_HI = 2'd1;
   localparam logic [1:0] REG_FSTATUS  = 2'd2;
   localparam logic [1:0] REG_FADDR    = 2'd3;

   // Storage and architectural registers
   logic [XLEN-1:0] mem_q [DEPTH_WORDS];
   logic [CNTW-1:0] cycle_q,  cycle_d;
   logic [XLEN-1:0] shadow_q, shadow_d;
   logic [FSW-1:0]  status_q, status_d;
   logic [XLEN-1:0] faddr_q,  faddr_d;
   logic [XLEN-1:0] out_q,    out_d;
   logic            fault_q,  fault_d;

   // Decode results
   logic [1:0]      byte_off;
   logic [IDXW-1:0] word_idx;
   logic            ram_hit;
   logic            mmio_sel;
   logic            mmio_reg_hit;
   logic [1:0]      reg_off;
   logic            we_legal;
   logic            is_write;
   logic            misalign;
   logic            range_err;
   logic [FSW-1:0]  fault_bits;
   logic            write_ok;
   logic            ram_we;
   logic            status_clr;
   logic [NB-1:0]   lane_be;
   logic [XLEN-1:0] lane_wd;
   logic [XLEN-1:0] ram_word;
   logic [XLEN-1:0] rdata;

   // Address decode, write classification and fault detection
   always_comb begin
      byte_off     = data_mem_addr[1:0];
      word_idx     = data_mem_addr[IDXW+1:2];
      ram_hit      = (data_mem_addr[XLEN-1:IDXW+2] == '0);
      mmio_sel     = (data_mem_addr[XLEN-1:XLEN-4] == MMIO_BASE[XLEN-1:XLEN-4]);
      mmio_reg_hit = mmio_sel && (data_mem_addr[XLEN-5:4] == '0);
      reg_off      = data_mem_addr[3:2];

      we_legal = 1'b0;
      case (data_mem_we)
         WE_NONE, WE_BYTE, WE_HALF, WE_WORD: we_legal = 1'b1;
         default:                            we_legal = 1'b0;
      endcase

      is_write   = we_legal && (data_mem_we != WE_NONE);
      misalign   = ((data_mem_we == WE_HALF) && data_mem_addr[0]) ||
                   ((data_mem_we == WE_WORD) && (byte_off != 2'b00));
      range_err  = is_write && !ram_hit && !mmio_sel;
      fault_bits = {!we_legal, range_err, misalign};

      write_ok   = is_write && !misalign && !range_err;
      ram_we     = write_ok && ram_hit && !rst;
      status_clr = write_ok && mmio_reg_hit && (reg_off == REG_FSTATUS);
   end

   // Byte-lane enables and replicated write data for the right-aligned store
   always_comb begin
      lane_be = '0;
      lane_wd = data_mem_wdata;
      case (data_mem_we)
         WE_BYTE: begin
            lane_be = NB'(1) << byte_off;
            lane_wd = {NB{data_mem_wdata[7:0]}};
         end
         WE_HALF: begin
            lane_be = byte_off[1] ? NB'(4'b1100) : NB'(4'b0011);
            lane_wd = {(NB/2){data_mem_wdata[15:0]}};
         end
         WE_WORD: begin
            lane_be = '1;
            lane_wd = data_mem_wdata;
         end
         default: begin
            lane_be = '0;
            lane_wd = data_mem_wdata;
         end
      endcase
   end

   // Read mux: RAM word shifted down to the addressed byte, or MMIO register
   always_comb begin
      ram_word = mem_q[word_idx];
      rdata    = '0;
      if (ram_hit) begin
         rdata = ram_word >> {byte_off, 3'b000};
      end else if (mmio_reg_hit) begin
         case (reg_off)
            REG_CYCLE_LO: rdata = XLEN'(cycle_q[31:0]);
            REG_CYCLE_HI: rdata = shadow_q;
            REG_FSTATUS:  rdata = XLEN'(status_q);
            REG_FADDR:    rdata = faddr_q;
            default:      rdata = '0;
         endcase
      end
   end

   // Next-state for counter, shadow, fault registers and read data
   always_comb begin
      cycle_d  = cycle_q + CNTW'(1);
      shadow_d = shadow_q;
      if (mmio_reg_hit && (reg_off == REG_CYCLE_LO)) begin
         shadow_d = XLEN'(cycle_q[63:32]);
      end
      status_d = status_clr ? '0 : (status_q | fault_bits);
      faddr_d  = faddr_q;
      if ((fault_bits != '0) && (status_q == '0)) begin
         faddr_d = data_mem_addr;
      end
      out_d   = rdata;
      fault_d = |status_q;
   end

   // Control and status registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q  <= '0;
         shadow_q <= '0;
         status_q <= '0;
         faddr_q  <= '0;
         out_q    <= '0;
         fault_q  <= 1'b0;
      end else begin
         cycle_q  <= cycle_d;
         shadow_q <= shadow_d;
         status_q <= status_d;
         faddr_q  <= faddr_d;
         out_q    <= out_d;
         fault_q  <= fault_d;
      end
   end

   // RAM byte-lane write; contents survive reset
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < int'(NB); b++) begin
            if (lane_be[b]) begin
               mem_q[word_idx][8*b +: 8] <= lane_wd[8*b +: 8];
            end
         end
      end
   end

   assign data_mem_out = out_q;
   assign fault        = fault_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that sits on the core's data-memory port. It receives data_mem_addr, data_mem_wdata and data_mem_we from the memory-access stage and returns data_mem_out.
- Contains single-port word RAM with byte-lane writes and a read-first synchronous read.
- Also contains a small MMIO region: a 64-bit cycle counter with a coherent high-word shadow, and a sticky access-fault status/address pair.
- Instantiated beside the core at SoC top level.

Parameters:
- XLEN, 32, data/address width.
- DEPTH_WORDS, 1024, RAM depth in 32-bit words (power of two); RAM region is 0x0000_0000 .. DEPTH_WORDS*4-1.
- MMIO_BASE, 32'hF000_0000, base address of the MMIO region; decoded on addr[31:28].

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous and active-high; one clock.
- data_mem_addr  input  XLEN  byte address from core.
- data_mem_wdata  input  XLEN  write data, right-aligned (byte in [7:0], half in [15:0]).
- data_mem_we  input  3  write enable: 000 none, 001 byte, 010 half, 100 word; any other code is illegal.
- data_mem_out  output  XLEN  registered read data.
- fault  output  1  OR of sticky fault status bits.

Behaviour:
Reset
- rst high at a clock edge clears data_mem_out, the cycle counter, the shadow register, fault status and fault address.
- RAM contents are not reset.
- A write presented in the same cycle as rst is dropped.

Read path (every cycle, no read enable)
- Latency 1: data_mem_out at edge N+1 reflects data_mem_addr at edge N.
- RAM read is read-first: a same-cycle write to the same word returns the old word.
- RAM hit: returns word[addr>>2] shifted right by addr[1:0]*8, zero-filled. The core performs sign/zero extension.
- Address in RAM region with word index >= DEPTH_WORDS: returns 0.
- Unmapped address (neither RAM nor MMIO): returns 0.

MMIO map (offsets from MMIO_BASE, word access)
- +0x0 CYCLE_LO: returns counter[31:0] and, on the same edge, latches counter[63:32] into the shadow.
- +0x4 CYCLE_HI: returns the shadow.
- +0x8 FAULT_STATUS [2:0]: bit0 misaligned, bit1 out-of-range, bit2 illegal we. Any write with legal we clears all bits.
- +0xC FAULT_ADDR: address of the first fault since last clear.
- Writes to CYCLE_LO, CYCLE_HI and FAULT_ADDR are ignored.

Cycle counter
- 64-bit, increments every non-reset cycle.
- Wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.

Write path (committed at the edge)
- Byte: lane addr[1:0] receives wdata[7:0].
- Half: lanes {addr[1],0} and {addr[1],1} receive wdata[15:0].
- Word: all four lanes receive wdata.

Faults (write suppressed, status sticky until cleared)
- Half with addr[0]=1, or word with addr[1:0]!=0: set bit0.
- RAM-region write with word index >= DEPTH_WORDS, or a write to an unmapped address: set bit1.
- Illegal we code: set bit2.
- FAULT_ADDR captures data_mem_addr only when status is all-zero before the edge.
- Later faults OR additional bits into status but do not update FAULT_ADDR.
- fault = |FAULT_STATUS, registered, so it asserts one cycle after the faulting edge.
- Reads never fault.

Test Plan:
1. Reset, then word write 0x1234_5678 to 0x10, read 0x10 -> data_mem_out = 0x1234_5678 one cycle after address; read 0x13 -> 0x0000_0012.
2. Byte write 0xAB to 0x11, then half write 0xCDEF to 0x12 -> word at 0x10 reads 0xCDEF_AB78; a same-cycle write+read of 0x10 returns the pre-write word.
3. Half write to 0x21 -> RAM unchanged, next cycle fault=1, FAULT_STATUS=0x1, FAULT_ADDR=0x21. Then we=011 to 0x40 -> STATUS=0x5, FAULT_ADDR still 0x21. Write to 0xF000_0008 -> STATUS=0, fault=0.
4. Word write to DEPTH_WORDS*4 -> status bit1 set, read of that address = 0.
5. Preload counter near 0x0000_0000_FFFF_FFFF (force or long run). Read CYCLE_LO then CYCLE_HI across the 32-bit carry -> HI equals the upper word at the LO-read edge, not the post-carry value. Also verify 64-bit wrap to 0.
6. Assert rst during a word write and while fault=1 -> write dropped, fault=0, data_mem_out=0, counter=0 next cycle, RAM elsewhere unchanged.
